// File: rtl/fix_serializer.sv
// rtl/fix_serializer.sv - FIX tag/value byte serializer; define FIX_SER_CHECKSUM_EN for the tag-10 trailer
module fix_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data_i,
  input  logic       in_kind_i,
  input  logic       in_last_i,
  input  logic       in_msg_last_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       new_message_o,
  output logic       end_message_o,
  output logic       err_o
);

  localparam logic [7:0] EQ_BYTE  = 8'h3D;
  localparam logic [7:0] SOH_BYTE = 8'h01;

  typedef enum logic [3:0] {
    IDLE, PRE, TAG, EQ, VAL, SOH
`ifdef FIX_SER_CHECKSUM_EN
    , CK1, CK0, CKEQ, CKD2, CKD1, CKD0, CKSOH
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hold_q;
  logic       hold_last_q;
  logic       final_q;

  logic       slot_free;
  logic       accept;
  logic       load;
  logic [7:0] load_byte;
  logic       load_end;
  logic       hold_we;
  logic       final_we;
  logic       err_d;

  assign slot_free     = ~out_valid_o | out_ready_i;
  assign in_ready_o    = ~rst & slot_free &
                         ((state_q == IDLE) | (state_q == TAG) | (state_q == VAL));
  assign accept        = in_valid_i & in_ready_o;
  assign new_message_o = (state_q == PRE);

`ifdef FIX_SER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       trailer;
  logic [7:0] ck_d2, ck_d1, ck_d0;

  // The running sum stops at the final SOH, so trailer bytes never feed back into it.
  assign trailer = (state_q == CK1)  | (state_q == CK0)  | (state_q == CKEQ) |
                   (state_q == CKD2) | (state_q == CKD1) | (state_q == CKD0) |
                   (state_q == CKSOH);
  assign ck_d2 = 8'h30 + (sum_q / 8'd100);
  assign ck_d1 = 8'h30 + ((sum_q / 8'd10) % 8'd10);
  assign ck_d0 = 8'h30 + (sum_q % 8'd10);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, output-slot load selection and side effects of each accepted byte.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_byte = 8'h00;
    load_end  = 1'b0;
    hold_we   = 1'b0;
    final_we  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_kind_i) begin
            hold_we = 1'b1;
            state_d = PRE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRE: begin
        // Slot is always empty here: IDLE only accepts when it is free.
        load      = 1'b1;
        load_byte = hold_q;
        state_d   = TAG;
      end
      TAG: begin
        if (accept) begin
          load = 1'b1;
          if (!in_kind_i) begin
            load_byte = in_data_i;
          end else begin
            hold_we   = 1'b1;
            final_we  = 1'b1;
            load_byte = EQ_BYTE;
`ifndef FIX_SER_CHECKSUM_EN
            load_end  = in_msg_last_i;
`endif
            state_d   = EQ;
          end
        end
      end
      EQ: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = hold_q;
          state_d   = hold_last_q ? SOH : VAL;
        end
      end
      VAL: begin
        if (accept) begin
          if (in_kind_i) begin
            load      = 1'b1;
            load_byte = in_data_i;
            if (in_last_i) state_d = SOH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SOH: begin
        if (slot_free) begin
          load      = 1'b1;
          load_byte = SOH_BYTE;
`ifdef FIX_SER_CHECKSUM_EN
          state_d   = final_q ? CK1 : TAG;
`else
          state_d   = final_q ? IDLE : TAG;
`endif
        end
      end
`ifdef FIX_SER_CHECKSUM_EN
      CK1:   if (slot_free) begin load = 1'b1; load_byte = 8'h31;    state_d = CK0;   end
      CK0:   if (slot_free) begin load = 1'b1; load_byte = 8'h30;    state_d = CKEQ;  end
      CKEQ:  if (slot_free) begin load = 1'b1; load_byte = EQ_BYTE;  load_end = 1'b1; state_d = CKD2; end
      CKD2:  if (slot_free) begin load = 1'b1; load_byte = ck_d2;    state_d = CKD1;  end
      CKD1:  if (slot_free) begin load = 1'b1; load_byte = ck_d1;    state_d = CKD0;  end
      CKD0:  if (slot_free) begin load = 1'b1; load_byte = ck_d0;    state_d = CKSOH; end
      CKSOH: if (slot_free) begin load = 1'b1; load_byte = SOH_BYTE; state_d = IDLE;  end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output slot, hold byte, field-final flag and error strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o        <= 8'h00;
      out_valid_o   <= 1'b0;
      end_message_o <= 1'b0;
      err_o         <= 1'b0;
      hold_q        <= 8'h00;
      hold_last_q   <= 1'b0;
      final_q       <= 1'b0;
    end else begin
      if (load) begin
        data_o        <= load_byte;
        out_valid_o   <= 1'b1;
        end_message_o <= load_end;
      end else if (out_ready_i) begin
        out_valid_o   <= 1'b0;
        end_message_o <= 1'b0;
      end
      if (hold_we) begin
        hold_q      <= in_data_i;
        hold_last_q <= in_kind_i & in_last_i;
      end
      if (final_we) final_q <= in_msg_last_i;
      err_o <= err_d;
    end
  end

`ifdef FIX_SER_CHECKSUM_EN
  // Checksum over every emitted byte of the message; restarts with the held first tag byte.
  always_ff @(posedge clk) begin
    if (rst)                   sum_q <= 8'h00;
    else if (state_q == PRE)   sum_q <= hold_q;
    else if (load && !trailer) sum_q <= sum_q + load_byte;
  end
`endif

endmodule
